pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter XLEN, default 32: width of every PC/address port.
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000: PC value loaded on reset.
REQ-003 Parameter INC, default 4, power of two: sequential step in bytes; ALIGN_BITS = log2(INC).
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 reset  input  1  asynchronous active-low reset.
REQ-007 stall  input  1  hold the sequential advance.
REQ-008 fetch_ready  input  1  fetch stage accepts the current pc.
REQ-009 fetch_valid  output  1  pc is valid for fetch.
REQ-010 pc  output  XLEN  current fetch PC.
REQ-011 pc_plus  output  XLEN  pc + INC, combinational.
REQ-012 redirect_en  input  1  branch/jump resolved taken.
REQ-013 redirect_pc  input  XLEN  branch/jump target.
REQ-014 trap_en  input  1  take a trap.
REQ-015 trap_vec  input  XLEN  trap handler address.
REQ-016 trap_pc  input  XLEN  PC of the trapping instruction.
REQ-017 mret_en  input  1  return from trap.
REQ-018 epc  output  XLEN  saved exception PC.
REQ-019 halt_req  input  1  request halt.
REQ-020 resume  input  1  leave halt.
REQ-021 halted  output  1  block is in HALT.
REQ-022 misalign_err  output  1  one-cycle pulse: target had nonzero low bits.

Function
REQ-023 States: BOOT, RUN, HALT; BOOT -> RUN unconditionally on the first edge after reset release.
REQ-024 fetch_valid SHALL be 1 only in RUN; halted SHALL be 1 only in HALT.
REQ-025 Update priority per edge: trap_en > mret_en > redirect_en > sequential advance.
REQ-026 trap_en (any state): pc <= aligned trap_vec, epc <= trap_pc, state <= RUN.
REQ-027 mret_en (no trap): pc <= epc; epc unchanged.
REQ-028 redirect_en (no trap/mret): pc <= aligned redirect_pc; in HALT, pc updates and state stays HALT.
REQ-029 Trap, mret and redirect SHALL override stall and ignore fetch_ready (flush beats stall).
REQ-030 Sequential advance: pc <= pc + INC iff state==RUN, fetch_ready=1, stall=0, and no higher-priority event.
REQ-031 Otherwise pc SHALL hold.
REQ-032 Arithmetic modulo 2^XLEN: all-ones-region PC wraps to 0 without error.
REQ-033 Aligned target = target with low ALIGN_BITS cleared.
REQ-034 misalign_err SHALL be 1 in the cycle after a taken trap/redirect whose target had nonzero low ALIGN_BITS, else 0.
REQ-035 halt_req in RUN with no trap: state <= HALT at the edge; a same-edge redirect/mret/advance still updates pc.
REQ-036 resume in HALT with no trap: state <= RUN; halt_req and resume together in HALT: resume wins.
REQ-037 Under mret_en in HALT: pc <= epc, state stays HALT.

Reset
REQ-038 While reset=0: pc=RESET_VECTOR, epc=0, state=BOOT, fetch_valid=0, halted=0, misalign_err=0, asynchronously.
REQ-039 Reset asserted mid-operation SHALL discard any in-flight redirect/trap; first post-reset fetch is RESET_VECTOR.

Verification
REQ-040 Release reset, fetch_ready=1, stall=0 -> fetch_valid 0 for one cycle, then pc 0x0, 0x4, 0x8 on successive cycles.
REQ-041 stall=1 at pc=0x10 for 3 cycles with redirect_en, redirect_pc=0x100 in cycle 2 -> pc 0x10, then 0x100, held until stall=0, then 0x104.
REQ-042 Same cycle trap_en (trap_vec=0x200, trap_pc=0x40), redirect_en (0x80) -> pc 0x200, epc 0x40; later mret_en -> pc 0x40.
REQ-043 redirect_pc=0x103 -> pc 0x100, misalign_err 1 for exactly one cycle.
REQ-044 halt_req at pc=0x20 -> halted 1, fetch_valid 0, pc 0x24 held; resume -> RUN, pc 0x24, 0x28.
REQ-045 pc=0xFFFF_FFFC advancing -> pc 0x0, misalign_err 0.

Source files
------------

// File: rtl/pc_gen.sv
// pc_gen: fetch program-counter generator.
// Holds the fetch PC and the saved exception PC, and runs a small
// BOOT/RUN/HALT control FSM. Traps, trap returns and redirects win over
// stall and fetch_ready. Sequential advance happens only in RUN.
module pc_gen #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     INC          = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            fetch_ready,
    output logic            fetch_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus,
    input  logic            redirect_en,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            trap_en,
    input  logic [XLEN-1:0] trap_vec,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            mret_en,
    output logic [XLEN-1:0] epc,
    input  logic            halt_req,
    input  logic            resume,
    output logic            halted,
    output logic            misalign_err
);

    localparam int unsigned     ALIGN_BITS = $clog2(INC);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);
    localparam logic [XLEN-1:0] INC_X      = XLEN'(INC);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [XLEN-1:0] pc_nxt;
    logic [XLEN-1:0] epc_nxt;
    logic            misalign_nxt;

    // Clear the low ALIGN_BITS of a control-flow target.
    function automatic logic [XLEN-1:0] align_addr(input logic [XLEN-1:0] a);
        return a & ~ALIGN_MASK;
    endfunction

    // A target is misaligned when any of its low ALIGN_BITS is set.
    function automatic logic is_misaligned(input logic [XLEN-1:0] a);
        return |(a & ALIGN_MASK);
    endfunction

    // Sequential successor; wraps modulo 2^XLEN by construction.
    assign pc_plus = pc + INC_X;

    // Next PC/EPC/state: trap > mret > redirect > sequential advance.
    always_comb begin
        pc_nxt       = pc;
        epc_nxt      = epc;
        state_nxt    = state;
        misalign_nxt = 1'b0;
        if (trap_en) begin
            pc_nxt       = align_addr(trap_vec);
            epc_nxt      = trap_pc;
            state_nxt    = RUN;
            misalign_nxt = is_misaligned(trap_vec);
        end else begin
            if (mret_en) begin
                pc_nxt = epc;
            end else if (redirect_en) begin
                pc_nxt       = align_addr(redirect_pc);
                misalign_nxt = is_misaligned(redirect_pc);
            end else if ((state == RUN) && fetch_ready && !stall) begin
                pc_nxt = pc_plus;
            end
            // Mode changes are independent of the PC update on the same edge.
            case (state)
                BOOT:    state_nxt = RUN;
                RUN:     state_nxt = halt_req ? HALT : RUN;
                HALT:    state_nxt = resume ? RUN : HALT;
                default: state_nxt = BOOT;
            endcase
        end
    end

    // State, PCs and registered status outputs; reset discards any pending flow change.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= BOOT;
            pc           <= RESET_VECTOR;
            epc          <= '0;
            fetch_valid  <= 1'b0;
            halted       <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            state        <= state_nxt;
            pc           <= pc_nxt;
            epc          <= epc_nxt;
            fetch_valid  <= (state_nxt == RUN);
            halted       <= (state_nxt == HALT);
            misalign_err <= misalign_nxt;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed scenarios plus a randomized run against a
// behavioural model of the PC generator rules.
module tb_pc_gen;

    localparam int STEP   = 4;
    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        trap_en;
    logic [31:0] trap_vec;
    logic [31:0] trap_pc;
    logic        mret_en;
    logic [31:0] epc;
    logic        halt_req;
    logic        resume;
    logic        halted;
    logic        misalign_err;

    int n_cmp = 0;
    int n_err = 0;

    // model state
    logic [31:0] m_pc;
    logic [31:0] m_epc;
    int          m_mode;
    logic        m_mis;

    pc_gen dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .fetch_ready  (fetch_ready),
        .fetch_valid  (fetch_valid),
        .pc           (pc),
        .pc_plus      (pc_plus),
        .redirect_en  (redirect_en),
        .redirect_pc  (redirect_pc),
        .trap_en      (trap_en),
        .trap_vec     (trap_vec),
        .trap_pc      (trap_pc),
        .mret_en      (mret_en),
        .epc          (epc),
        .halt_req     (halt_req),
        .resume       (resume),
        .halted       (halted),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall       = 1'b0;
        fetch_ready = 1'b1;
        redirect_en = 1'b0;
        redirect_pc = 32'h0;
        trap_en     = 1'b0;
        trap_vec    = 32'h0;
        trap_pc     = 32'h0;
        mret_en     = 1'b0;
        halt_req    = 1'b0;
        resume      = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        trap_en  = 1'b1;
        trap_vec = 32'h0000_0203;
        trap_pc  = 32'h0000_0044;
        tick();
        tick();
        n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
        n_cmp++; if (epc !== 32'h0) begin n_err++; $display("FAIL reset_epc: got %h want %h", epc, 32'h0); end
        n_cmp++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL reset_fetch_valid: got %b want 0", fetch_valid); end
        n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted: got %b want 0", halted); end
        n_cmp++; if (misalign_err !== 1'b0) begin n_err++; $display("FAIL reset_misalign: got %b want 0", misalign_err); end
        clear_inputs();
    endtask

    task automatic test_sequential();
        reset = 1'b1;
        n_cmp++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL boot_fetch_valid: got %b want 0", fetch_valid); end
        tick();
        n_cmp++; if (fetch_valid !== 1'b1) begin n_err++; $display("FAIL run_fetch_valid: got %b want 1", fetch_valid); end
        n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL seq_pc0: got %h want %h", pc, 32'h0); end
        n_cmp++; if (pc_plus !== 32'h4) begin n_err++; $display("FAIL seq_pc_plus: got %h want %h", pc_plus, 32'h4); end
        tick();
        n_cmp++; if (pc !== 32'h4) begin n_err++; $display("FAIL seq_pc4: got %h want %h", pc, 32'h4); end
        tick();
        n_cmp++; if (pc !== 32'h8) begin n_err++; $display("FAIL seq_pc8: got %h want %h", pc, 32'h8); end
    endtask

    task automatic test_stall_redirect();
        redirect_en = 1'b1; redirect_pc = 32'h10;
        tick();
        redirect_en = 1'b0;
        n_cmp++; if (pc !== 32'h10) begin n_err++; $display("FAIL stall_setup: got %h want %h", pc, 32'h10); end
        stall = 1'b1;
        tick();
        n_cmp++; if (pc !== 32'h10) begin n_err++; $display("FAIL stall_hold: got %h want %h", pc, 32'h10); end
        redirect_en = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect_en = 1'b0;
        n_cmp++; if (pc !== 32'h100) begin n_err++; $display("FAIL stall_redirect: got %h want %h", pc, 32'h100); end
        tick();
        n_cmp++; if (pc !== 32'h100) begin n_err++; $display("FAIL stall_hold2: got %h want %h", pc, 32'h100); end
        stall = 1'b0;
        tick();
        n_cmp++; if (pc !== 32'h104) begin n_err++; $display("FAIL stall_release: got %h want %h", pc, 32'h104); end
    endtask

    task automatic test_trap_priority();
        trap_en = 1'b1; trap_vec = 32'h200; trap_pc = 32'h40;
        redirect_en = 1'b1; redirect_pc = 32'h80;
        tick();
        clear_inputs();
        n_cmp++; if (pc !== 32'h200) begin n_err++; $display("FAIL trap_pc: got %h want %h", pc, 32'h200); end
        n_cmp++; if (epc !== 32'h40) begin n_err++; $display("FAIL trap_epc: got %h want %h", epc, 32'h40); end
        stall = 1'b1;
        tick();
        n_cmp++; if (pc !== 32'h200) begin n_err++; $display("FAIL trap_hold: got %h want %h", pc, 32'h200); end
        mret_en = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h300;
        tick();
        clear_inputs();
        n_cmp++; if (pc !== 32'h40) begin n_err++; $display("FAIL mret_pc: got %h want %h", pc, 32'h40); end
        n_cmp++; if (epc !== 32'h40) begin n_err++; $display("FAIL mret_epc: got %h want %h", epc, 32'h40); end
    endtask

    task automatic test_misalign();
        redirect_en = 1'b1; redirect_pc = 32'h103;
        tick();
        redirect_en = 1'b0;
        n_cmp++; if (pc !== 32'h100) begin n_err++; $display("FAIL misalign_pc: got %h want %h", pc, 32'h100); end
        n_cmp++; if (misalign_err !== 1'b1) begin n_err++; $display("FAIL misalign_pulse: got %b want 1", misalign_err); end
        tick();
        n_cmp++; if (misalign_err !== 1'b0) begin n_err++; $display("FAIL misalign_clear: got %b want 0", misalign_err); end
        n_cmp++; if (pc !== 32'h104) begin n_err++; $display("FAIL misalign_next: got %h want %h", pc, 32'h104); end
        trap_en = 1'b1; trap_vec = 32'h301; trap_pc = 32'h104;
        tick();
        trap_en = 1'b0;
        n_cmp++; if (pc !== 32'h300) begin n_err++; $display("FAIL trap_align: got %h want %h", pc, 32'h300); end
        n_cmp++; if (misalign_err !== 1'b1) begin n_err++; $display("FAIL trap_misalign: got %b want 1", misalign_err); end
    endtask

    task automatic test_halt_resume();
        redirect_en = 1'b1; redirect_pc = 32'h20;
        tick();
        redirect_en = 1'b0;
        halt_req = 1'b1;
        tick();
        n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL halt_flag: got %b want 1", halted); end
        n_cmp++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL halt_fetch_valid: got %b want 0", fetch_valid); end
        n_cmp++; if (pc !== 32'h24) begin n_err++; $display("FAIL halt_pc: got %h want %h", pc, 32'h24); end
        halt_req = 1'b0;
        tick();
        n_cmp++; if (pc !== 32'h24) begin n_err++; $display("FAIL halt_hold: got %h want %h", pc, 32'h24); end
        halt_req = 1'b1; resume = 1'b1;
        tick();
        halt_req = 1'b0; resume = 1'b0;
        n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL resume_halted: got %b want 0", halted); end
        n_cmp++; if (fetch_valid !== 1'b1) begin n_err++; $display("FAIL resume_fetch_valid: got %b want 1", fetch_valid); end
        n_cmp++; if (pc !== 32'h24) begin n_err++; $display("FAIL resume_pc: got %h want %h", pc, 32'h24); end
        tick();
        n_cmp++; if (pc !== 32'h28) begin n_err++; $display("FAIL resume_adv: got %h want %h", pc, 32'h28); end
    endtask

    task automatic test_wrap();
        redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_en = 1'b0;
        n_cmp++; if (pc_plus !== 32'h0) begin n_err++; $display("FAIL wrap_pc_plus: got %h want %h", pc_plus, 32'h0); end
        tick();
        n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL wrap_pc: got %h want %h", pc, 32'h0); end
        n_cmp++; if (misalign_err !== 1'b0) begin n_err++; $display("FAIL wrap_misalign: got %b want 0", misalign_err); end
    endtask

    task automatic test_reset_midflight();
        redirect_en = 1'b1; redirect_pc = 32'h500;
        tick();
        trap_en = 1'b1; trap_vec = 32'h700; trap_pc = 32'h500;
        #2;
        reset = 1'b0;
        #1;
        n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL async_reset_pc: got %h want %h", pc, 32'h0); end
        n_cmp++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL async_reset_valid: got %b want 0", fetch_valid); end
        tick();
        clear_inputs();
        tick();
        reset = 1'b1;
        tick();
        n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL post_reset_pc: got %h want %h", pc, 32'h0); end
        n_cmp++; if (epc !== 32'h0) begin n_err++; $display("FAIL post_reset_epc: got %h want %h", epc, 32'h0); end
    endtask

    // Behavioural view of one clock edge, from the current inputs.
    task automatic model_edge();
        logic [31:0] low;
        m_mis = 1'b0;
        if (trap_en) begin
            low    = trap_vec % STEP;
            m_pc   = trap_vec - low;
            m_mis  = (low != 0);
            m_epc  = trap_pc;
            m_mode = M_RUN;
        end else begin
            if (mret_en) begin
                m_pc = m_epc;
            end else if (redirect_en) begin
                low   = redirect_pc % STEP;
                m_pc  = redirect_pc - low;
                m_mis = (low != 0);
            end else if (m_mode == M_RUN && fetch_ready && !stall) begin
                m_pc = 32'(64'(m_pc) + STEP);
            end
            if (m_mode == M_BOOT) m_mode = M_RUN;
            else if (m_mode == M_RUN && halt_req) m_mode = M_HALT;
            else if (m_mode == M_HALT && resume) m_mode = M_RUN;
        end
    endtask

    task automatic test_random();
        clear_inputs();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        m_pc = 32'h0; m_epc = 32'h0; m_mode = M_BOOT; m_mis = 1'b0;
        for (int i = 0; i < 500; i++) begin
            trap_en     = ($urandom_range(0, 15) == 0);
            mret_en     = ($urandom_range(0, 11) == 0);
            redirect_en = ($urandom_range(0, 7) == 0);
            halt_req    = ($urandom_range(0, 9) == 0);
            resume      = ($urandom_range(0, 3) == 0);
            stall       = ($urandom_range(0, 3) == 0);
            fetch_ready = ($urandom_range(0, 3) != 0);
            redirect_pc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            trap_vec    = $urandom;
            trap_pc     = $urandom;
            model_edge();
            tick();
            n_cmp++; if (pc !== m_pc) begin n_err++; $display("FAIL rnd_pc[%0d]: got %h want %h", i, pc, m_pc); end
            n_cmp++; if (pc_plus !== 32'(64'(m_pc) + STEP)) begin n_err++; $display("FAIL rnd_pc_plus[%0d]: got %h want %h", i, pc_plus, 32'(64'(m_pc) + STEP)); end
            n_cmp++; if (epc !== m_epc) begin n_err++; $display("FAIL rnd_epc[%0d]: got %h want %h", i, epc, m_epc); end
            n_cmp++; if (fetch_valid !== (m_mode == M_RUN)) begin n_err++; $display("FAIL rnd_fetch_valid[%0d]: got %b want %b", i, fetch_valid, (m_mode == M_RUN)); end
            n_cmp++; if (halted !== (m_mode == M_HALT)) begin n_err++; $display("FAIL rnd_halted[%0d]: got %b want %b", i, halted, (m_mode == M_HALT)); end
            n_cmp++; if (misalign_err !== m_mis) begin n_err++; $display("FAIL rnd_misalign[%0d]: got %b want %b", i, misalign_err, m_mis); end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        reset = 1'b0;
        #1;
        test_reset();
        test_sequential();
        test_stall_redirect();
        test_trap_priority();
        test_misalign();
        test_halt_resume();
        test_wrap();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
